ila_readout_ctrl: RTL and testbench

Readout sequencer for the ILA sample buffer, running in the system clock domain.
- On a start command it snapshots the synchronized sample count.
- It walks every stored sample and every DATA_W-wide slice of each sample by driving the buffer read index and slice select.
- It waits the fixed read latency of the buffer plus output register.
- It streams each word on a valid/ready interface to the software/DMA side.

---
 rtl/ila_readout_pkg.sv | 28 ++
 rtl/ila_readout_ctrl.sv | 125 ++++++++++++
 tb/tb_ila_readout_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ila_readout_pkg.sv
// Shared types and width helpers for the ILA readout sequencer.
// The datapath reuses NWORDS/SEL_W so its slice mux width always agrees with the sequencer.
package ila_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int calc_nwords(input int signal_w, input int data_w);
        int n;
        n = ceil_div(signal_w, data_w);
        return (n < 1) ? 1 : n;
    endfunction

    // Select/counter width, never narrower than one bit.
    function automatic int calc_sel_w(input int nvals);
        return (nvals <= 1) ? 1 : $clog2(nvals);
    endfunction

endpackage

// File: rtl/ila_readout_ctrl.sv
// Walks every stored sample and slice, waits RD_LAT, then offers each word on valid/ready.
// Not pipelined: one word per 2+RD_LAT cycles; a word holds in OUT until accepted.
module ila_readout_ctrl
    import ila_readout_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SIGNAL_W = 64,
    parameter int BUFFER_W = 4,
    parameter int RD_LAT   = 2,
    localparam int NWORDS  = calc_nwords(SIGNAL_W, DATA_W),
    localparam int SEL_W   = calc_sel_w(NWORDS)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [BUFFER_W-1:0] samples_i,
    output logic [BUFFER_W-1:0] index_o,
    output logic [SEL_W-1:0]    value_select_o,
    input  logic [DATA_W-1:0]   value_i,
    output logic [DATA_W-1:0]   m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                m_sol_o,
    output logic                m_last_o,
    output logic [BUFFER_W-1:0] count_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int CNT_W = calc_sel_w(RD_LAT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             sel_at_max;
    logic             idx_at_max;
    logic             wait_over;

    assign sel_at_max = (value_select_o == SEL_W'(NWORDS - 1));
    assign idx_at_max = (index_o == (count_o - BUFFER_W'(1)));
    assign wait_over  = (wait_cnt == CNT_W'(RD_LAT - 1));

    assign m_valid_o = (state == ST_OUT);
    assign m_sol_o   = (state == ST_OUT) && (value_select_o == '0);
    assign m_last_o  = (state == ST_OUT) && sel_at_max && idx_at_max;
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= ST_IDLE;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_i) state_nxt = (samples_i == '0) ? ST_DONE : ST_FETCH;
                ST_FETCH: state_nxt = ST_WAIT;
                ST_WAIT:  if (wait_over) state_nxt = ST_OUT;
                ST_OUT:   if (m_ready_i) state_nxt = (sel_at_max && idx_at_max) ? ST_DONE : ST_FETCH;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Address is registered so it stays stable for the whole FETCH/WAIT window.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            index_o        <= '0;
            value_select_o <= '0;
            count_o        <= '0;
            wait_cnt       <= '0;
            m_data_o       <= '0;
        end else if (cke_i) begin
            if (abort_i) begin
                index_o        <= '0;
                value_select_o <= '0;
                wait_cnt       <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            count_o        <= samples_i;
                            index_o        <= '0;
                            value_select_o <= '0;
                        end
                    end
                    ST_FETCH: wait_cnt <= '0;
                    ST_WAIT: begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        if (wait_over) m_data_o <= value_i;
                    end
                    ST_OUT: begin
                        if (m_ready_i) begin
                            if (!sel_at_max) begin
                                value_select_o <= value_select_o + SEL_W'(1);
                            end else if (!idx_at_max) begin
                                value_select_o <= '0;
                                index_o        <= index_o + BUFFER_W'(1);
                            end else begin
                                value_select_o <= '0;
                                index_o        <= '0;
                            end
                        end
                    end
                    ST_DONE: begin
                        index_o        <= '0;
                        value_select_o <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Directed bench for ila_readout_ctrl with a two-stage buffer model returning {idx, slice} words.
module tb_ila_readout_ctrl;

    logic        clk = 1'b0;
    logic        arst;
    logic        cke;
    logic        start;
    logic        abort;
    logic [3:0]  samples;
    logic [3:0]  index;
    logic [0:0]  value_select;
    logic [31:0] value;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sol;
    logic        m_last;
    logic [3:0]  count;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ila_readout_ctrl dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .start_i(start), .abort_i(abort),
        .samples_i(samples), .index_o(index), .value_select_o(value_select),
        .value_i(value), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_sol_o(m_sol), .m_last_o(m_last), .count_o(count), .busy_o(busy), .done_o(done)
    );

    function automatic logic [31:0] word_of(input logic [3:0] idx, input logic sel);
        return 32'hC0DE_0000 | (32'(idx) << 8) | 32'(sel);
    endfunction

    // Buffer read path: two register stages from address to value.
    logic [31:0] rd_pipe;
    always @(posedge clk) begin
        rd_pipe <= word_of(index, value_select[0]);
        value   <= rd_pipe;
    end

    int          cyc = 0;
    int          cyc0 = 0;
    logic        mon_clr = 1'b0;
    logic [31:0] hs_dat[$];
    logic        hs_sol[$];
    logic        hs_last[$];
    int          hs_rel[$];
    int          first_vld = -1;
    int          done_rel = -1;
    int          done_cnt = 0;
    int          busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle 1 is the cycle right after the edge that samples start.
    always @(negedge clk) begin
        if (mon_clr) begin
            hs_dat.delete(); hs_sol.delete(); hs_last.delete(); hs_rel.delete();
            first_vld = -1; done_rel = -1; done_cnt = 0; busy_cnt = 0;
        end else begin
            if (m_valid && first_vld < 0) first_vld = cyc - cyc0 + 1;
            if (m_valid && m_ready && cke && !abort && !arst) begin
                hs_dat.push_back(m_data);
                hs_sol.push_back(m_sol);
                hs_last.push_back(m_last);
                hs_rel.push_back(cyc - cyc0 + 1);
            end
            if (done) begin
                if (done_cnt == 0) done_rel = cyc - cyc0 + 1;
                done_cnt++;
            end
            if (busy) busy_cnt++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [3:0] s);
        samples = s;
        start   = 1'b1;
        @(posedge clk);
        #1;
        cyc0  = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(done_cnt != 0), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_words(input string tag, input int nexp);
        chk({tag, "_nwords"}, 64'(hs_dat.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < hs_dat.size(); i++) begin
            chk({tag, "_data"}, 64'(hs_dat[i]), 64'(word_of(4'(i / 2), 1'(i % 2))));
            chk({tag, "_sol"},  64'(hs_sol[i]),  64'(i % 2 == 0));
            chk({tag, "_last"}, 64'(hs_last[i]), 64'(i == nexp - 1));
        end
    endtask

    initial begin
        int n;
        arst = 1'b1; cke = 1'b1; start = 1'b0; abort = 1'b0; samples = '0; m_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_busy",  64'(busy),    64'd0);
        chk("rst_done",  64'(done),    64'd0);
        chk("rst_index", 64'(index),   64'd0);
        chk("rst_sel",   64'(value_select), 64'd0);
        chk("rst_count", 64'(count),   64'd0);
        chk("rst_data",  64'(m_data),  64'd0);
        chk("rst_sollast", 64'({m_sol, m_last}), 64'd0);
        @(posedge clk);
        #1 arst = 1'b0;
        @(posedge clk);
        #1;

        // Basic three-sample dump with ready held high.
        reset_mon();
        start_dump(4'd3);
        wait_done("t1_done_seen", 100);
        chk("t1_first_vld", 64'(first_vld), 64'd4);
        check_words("t1", 6);
        if (hs_rel.size() > 1) chk("t1_hs2_cyc", 64'(hs_rel[1]), 64'd8);
        chk("t1_done_cyc", 64'(done_rel), 64'd25);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_count", 64'(count), 64'd3);

        // Empty buffer: straight to DONE.
        reset_mon();
        start_dump(4'd0);
        wait_done("t2_done_seen", 20);
        chk("t2_vld_seen", 64'(first_vld >= 0), 64'd0);
        chk("t2_done_cyc", 64'(done_rel), 64'd1);
        chk("t2_busy_cyc", 64'(busy_cnt), 64'd1);

        // Backpressure on word 1 of a two-sample dump.
        reset_mon();
        start_dump(4'd2);
        n = 0;
        while (hs_dat.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
        m_ready = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold", 64'({m_valid, index, m_sol, m_last, m_data}),
                64'({1'b1, 4'd0, 1'b0, 1'b0, word_of(4'd0, 1'b1)}));
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_done("t3_done_seen", 100);
        check_words("t3", 4);

        // Abort on the third handshake cycle, then restart.
        reset_mon();
        start_dump(4'd15);
        n = 0;
        while (!(hs_dat.size() == 2 && m_valid) && n < 100) begin @(posedge clk); #1; n++; end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("t4_busy",  64'(busy),  64'd0);
        chk("t4_valid", 64'(m_valid), 64'd0);
        chk("t4_addr",  64'({index, value_select}), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("t4_no_more_words", 64'(hs_dat.size()), 64'd2);
        chk("t4_no_done", 64'(done_cnt), 64'd0);
        reset_mon();
        start_dump(4'd1);
        wait_done("t4_restart_done", 100);
        check_words("t4r", 2);

        // Count snapshot; samples change and start while busy are ignored.
        reset_mon();
        start_dump(4'd5);
        repeat (6) @(posedge clk);
        #1;
        samples = 4'd9;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5_done_seen", 300);
        check_words("t5", 10);
        chk("t5_count", 64'(count), 64'd5);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);
        chk("t5_busy_after", 64'(busy), 64'd0);

        // Clock enable low for three cycles inside WAIT.
        reset_mon();
        start_dump(4'd1);
        @(posedge clk);
        #1 cke = 1'b0;
        repeat (3) @(posedge clk);
        #1 cke = 1'b1;
        wait_done("t6_done_seen", 100);
        chk("t6_first_vld", 64'(first_vld), 64'd7);
        check_words("t6", 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
